// File: rtl/ex_hazard_ctrl.sv
// Hazard/forwarding controller beside the ID/EX boundary: tracks EX/MEM/WB destinations,
// produces operand forward selects, load-use stall, branch flush and halt freeze.
module ex_hazard_ctrl #(
  parameter int unsigned REG_BITS     = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_wb,
  input  logic                id_load,
  input  logic                id_halt,
  input  logic                branch_taken,
  output logic                stall,
  output logic                bubble,
  output logic                flush,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                halted
);

  typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  state_e     r_state, w_state_next;
  logic [2:0] r_flush_cnt, w_flush_cnt_next;

  logic                r_ex_v, r_ex_wb, r_ex_load, r_ex_halt, r_ex_ua, r_ex_ub;
  logic [REG_BITS-1:0] r_ex_rd, r_ex_rs, r_ex_rt;
  logic                r_mem_v, r_mem_wb, r_mem_load, r_mem_halt;
  logic [REG_BITS-1:0] r_mem_rd;
  logic                r_wb_v, r_wb_wb, r_wb_halt;
  logic [REG_BITS-1:0] r_wb_rd;

  logic w_load_use, w_branch, w_squash, w_advance, w_wb_halt;

  assign w_load_use = id_valid & r_ex_v & r_ex_load & r_ex_wb & (r_ex_rd != '0) &
                      ((id_uses_rs & (id_rs == r_ex_rd)) | (id_uses_rt & (id_rt == r_ex_rd)));
  assign w_branch   = branch_taken & r_ex_v;
  assign w_wb_halt  = r_wb_v & r_wb_halt;
  assign w_squash   = bubble | flush;
  assign w_advance  = (r_state != StHalt);

  // MEM result wins over WB; a load in MEM never forwards (its data is not ready yet).
  always_comb begin
    fwd_a = 2'b00;
    if (r_ex_ua && r_mem_v && r_mem_wb && !r_mem_load && r_mem_rd != '0 &&
        r_mem_rd == r_ex_rs) begin
      fwd_a = 2'b01;
    end else if (r_ex_ua && r_wb_v && r_wb_wb && r_wb_rd != '0 && r_wb_rd == r_ex_rs) begin
      fwd_a = 2'b10;
    end
  end

  always_comb begin
    fwd_b = 2'b00;
    if (r_ex_ub && r_mem_v && r_mem_wb && !r_mem_load && r_mem_rd != '0 &&
        r_mem_rd == r_ex_rt) begin
      fwd_b = 2'b01;
    end else if (r_ex_ub && r_wb_v && r_wb_wb && r_wb_rd != '0 && r_wb_rd == r_ex_rt) begin
      fwd_b = 2'b10;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    stall            = 1'b0;
    bubble           = 1'b0;
    flush            = 1'b0;
    halted           = 1'b0;
    unique case (r_state)
      StRun: begin
        if (w_branch) begin
          // Flush takes priority over a simultaneous load-use stall.
          flush            = 1'b1;
          w_flush_cnt_next = FlushLoad;
          if (FlushLoad != 3'd0) w_state_next = StFlush;
        end else if (w_load_use) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
        if (w_wb_halt) w_state_next = StHalt;
      end
      StFlush: begin
        flush            = 1'b1;
        w_flush_cnt_next = r_flush_cnt - 3'd1;
        if (r_flush_cnt <= 3'd1) w_state_next = StRun;
        if (w_wb_halt) w_state_next = StHalt;
      end
      StHalt: begin
        halted = 1'b1;
        stall  = 1'b1;
        bubble = 1'b1;
      end
      default: w_state_next = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StRun;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_v     <= 1'b0;
      r_ex_wb    <= 1'b0;
      r_ex_load  <= 1'b0;
      r_ex_halt  <= 1'b0;
      r_ex_ua    <= 1'b0;
      r_ex_ub    <= 1'b0;
      r_ex_rd    <= '0;
      r_ex_rs    <= '0;
      r_ex_rt    <= '0;
      r_mem_v    <= 1'b0;
      r_mem_wb   <= 1'b0;
      r_mem_load <= 1'b0;
      r_mem_halt <= 1'b0;
      r_mem_rd   <= '0;
      r_wb_v     <= 1'b0;
      r_wb_wb    <= 1'b0;
      r_wb_halt  <= 1'b0;
      r_wb_rd    <= '0;
    end else if (w_advance) begin
      r_wb_v     <= r_mem_v;
      r_wb_wb    <= r_mem_wb;
      r_wb_halt  <= r_mem_halt;
      r_wb_rd    <= r_mem_rd;
      r_mem_v    <= r_ex_v;
      r_mem_wb   <= r_ex_wb;
      r_mem_load <= r_ex_load;
      r_mem_halt <= r_ex_halt;
      r_mem_rd   <= r_ex_rd;
      if (w_squash) begin
        // Bubble: zero every control field so the slot can neither forward nor stall.
        r_ex_v    <= 1'b0;
        r_ex_wb   <= 1'b0;
        r_ex_load <= 1'b0;
        r_ex_halt <= 1'b0;
        r_ex_ua   <= 1'b0;
        r_ex_ub   <= 1'b0;
        r_ex_rd   <= '0;
        r_ex_rs   <= '0;
        r_ex_rt   <= '0;
      end else begin
        r_ex_v    <= id_valid;
        r_ex_wb   <= id_wb;
        r_ex_load <= id_load;
        r_ex_halt <= id_halt;
        r_ex_ua   <= id_uses_rs;
        r_ex_ub   <= id_uses_rt;
        r_ex_rd   <= id_rd;
        r_ex_rs   <= id_rs;
        r_ex_rt   <= id_rt;
      end
    end
  end

endmodule
